// File: rtl/shift_pipe.sv
// ============================================================================
// Module   : shift_pipe
// Brief    : Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow
//            control on both sides and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data
);

    localparam int L   = $clog2(N);
    localparam int LPS = (L + STAGES - 1) / STAGES;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Slice registers
    logic [STAGES-1:0] valid_q;
    logic [N-1:0]      data_q  [STAGES];
    logic [L-1:0]      shamt_q [STAGES];
    logic [1:0]        op_q    [STAGES];
    logic [STAGES-1:0] sign_q;

    // Slice inputs (from the port for slice 0, from the previous slice otherwise)
    logic [STAGES-1:0] ready_w;
    logic [STAGES-1:0] up_valid_w;
    logic [N-1:0]      up_data_w  [STAGES];
    logic [L-1:0]      up_shamt_w [STAGES];
    logic [1:0]        up_op_w    [STAGES];
    logic [STAGES-1:0] up_sign_w;
    logic [N-1:0]      shifted_w  [STAGES];

    logic              unused_tail_w;

    function automatic logic [N-1:0] shift_level(
        input logic [N-1:0] x,
        input logic [1:0]   op,
        input logic         sgn,
        input int           amt
    );
        logic [N-1:0] ones;
        logic [N-1:0] res;
        ones = {N{1'b1}};
        case (op)
            OP_SLL:  res = x << amt;
            OP_SRL:  res = x >> amt;
            OP_SRA:  res = (x >> amt) | (sgn ? ~(ones >> amt) : '0);
            OP_ROR:  res = (x >> amt) | (x << (N - amt));
            default: res = x;
        endcase
        return res;
    endfunction

    // ready_s is high unless every slice from s to the head is occupied and
    // the consumer is stalling; written in closed form to avoid a comb chain
    // on a single vector.
    always_comb begin
        logic all_full;
        ready_w  = '0;
        all_full = 1'b1;
        for (int s = 0; s < STAGES; s++) begin
            all_full = 1'b1;
            for (int t = s; t < STAGES; t++) begin
                all_full = all_full & valid_q[t];
            end
            ready_w[s] = out_ready || !all_full;
        end
    end

    assign in_ready = ready_w[0] && !flush;

    always_comb begin
        up_valid_w = '0;
        up_data_w  = '{default: '0};
        up_shamt_w = '{default: '0};
        up_op_w    = '{default: '0};
        up_sign_w  = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (s == 0) begin
                up_valid_w[s] = in_valid && in_ready;
                up_data_w[s]  = in_data;
                up_shamt_w[s] = in_shamt;
                up_op_w[s]    = in_op;
                up_sign_w[s]  = in_data[N-1];
            end else begin
                up_valid_w[s] = valid_q[s-1];
                up_data_w[s]  = data_q[s-1];
                up_shamt_w[s] = shamt_q[s-1];
                up_op_w[s]    = op_q[s-1];
                up_sign_w[s]  = sign_q[s-1];
            end
        end
    end

    // Slice s owns levels [s*LPS, (s+1)*LPS); the last slice simply stops at L.
    always_comb begin
        logic [N-1:0] x;
        shifted_w = '{default: '0};
        x         = '0;
        for (int s = 0; s < STAGES; s++) begin
            x = up_data_w[s];
            for (int k = 0; k < L; k++) begin
                if (k >= s * LPS && k < (s + 1) * LPS && up_shamt_w[s][k]) begin
                    x = shift_level(x, up_op_w[s], up_sign_w[s], 1 << k);
                end
            end
            shifted_w[s] = x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            sign_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s]  <= '0;
                shamt_q[s] <= '0;
                op_q[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (flush) begin
                    valid_q[s] <= 1'b0;
                end else if (ready_w[s]) begin
                    valid_q[s] <= up_valid_w[s];
                end
                if (ready_w[s] && up_valid_w[s]) begin
                    data_q[s]  <= shifted_w[s];
                    shamt_q[s] <= up_shamt_w[s];
                    op_q[s]    <= up_op_w[s];
                    sign_q[s]  <= up_sign_w[s];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    // The head slice has no downstream consumer for its control fields.
    assign unused_tail_w = ^{shamt_q[STAGES-1], op_q[STAGES-1], sign_q[STAGES-1]};

endmodule

`default_nettype wire

// File: tb/tb_shift_pipe.sv
// ============================================================================
// Module   : tb_shift_pipe
// Brief    : Directed self-checking bench for shift_pipe (N=32, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_pipe;

    localparam int N      = 32;
    localparam int STAGES = 2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [4:0]    in_shamt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    int checks;
    int failures;

    shift_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: checks acceptance, 2-cycle latency and result.
    task automatic send_one(input string tag, input logic [31:0] d, input logic [4:0] sh,
                            input logic [1:0] op, input logic [31:0] exp);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
        #1;
        check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, "_lat"}, n, STAGES);
        check(tag, out_data, exp);
        step();
    endtask

    initial begin
        int idx;
        int got;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        in_shamt  = 5'd3;
        in_op     = OP_SLL;
        out_ready = 1'b1;

        // Reset with in_valid asserted
        repeat (3) step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("rst_no_emit", {31'b0, out_valid}, 32'd0);
        end

        // Mode vectors
        send_one("sra31", 32'h8000_0000, 5'd31, OP_SRA, 32'hFFFF_FFFF);
        send_one("srl31", 32'h8000_0000, 5'd31, OP_SRL, 32'h0000_0001);
        send_one("sll31", 32'h0000_0001, 5'd31, OP_SLL, 32'h8000_0000);
        send_one("ror4",  32'h0000_0001, 5'd4,  OP_ROR, 32'h1000_0000);
        send_one("ror8",  32'h1234_5678, 5'd8,  OP_ROR, 32'h7812_3456);
        send_one("sra_pos", 32'h7FFF_FFFF, 5'd4, OP_SRA, 32'h07FF_FFFF);
        send_one("sll16", 32'h0000_ABCD, 5'd16, OP_SLL, 32'hABCD_0000);

        // Identity streaming in all four modes back-to-back
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            in_data  = 32'hDEAD_BEEF;
            in_shamt = 5'd0;
            case (c)
                0:       in_op = OP_SLL;
                1:       in_op = OP_SRL;
                2:       in_op = OP_SRA;
                default: in_op = OP_ROR;
            endcase
            #1;
            if (c < 4) check("id_rdy", {31'b0, in_ready}, 32'd1);
            if (c >= 2 && c <= 5) begin
                check("id_valid", {31'b0, out_valid}, 32'd1);
                check("id_data", out_data, 32'hDEAD_BEEF);
            end
            step();
        end
        check("id_drain", {31'b0, out_valid}, 32'd0);

        // Backpressure: out_ready low for 5 cycles
        out_ready = 1'b0;
        idx = 0;
        got = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            in_data  = idx + 1;
            in_shamt = 5'd0;
            in_op    = OP_SRL;
            #1;
            check("bp_rdy", {31'b0, in_ready}, (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
                check("bp_hold_data", out_data, 32'd1);
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4);
            in_data  = idx + 1;
            #1;
            if (out_valid) begin
                check("bp_order", out_data, got + 1);
                got++;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        check("bp_count", got, 4);
        step();
        check("bp_drain", {31'b0, out_valid}, 32'd0);

        // Flush with two operations in flight
        in_valid = 1'b1;
        in_data  = 32'h0000_0100;
        in_shamt = 5'd0;
        in_op    = OP_SLL;
        step();
        in_data  = 32'h0000_0200;
        step();
        flush    = 1'b1;
        in_data  = 32'h0000_AAAA;
        #1;
        check("fl_rdy", {31'b0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_empty", {31'b0, out_valid}, 32'd0);
        step();
        check("fl_empty2", {31'b0, out_valid}, 32'd0);
        send_one("fl_sra4", 32'hF000_0000, 5'd4, OP_SRA, 32'hFF00_0000);

        // Asynchronous reset while the pipe is full
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h5555_0000 + c;
            in_shamt = 5'd1;
            in_op    = OP_ROR;
            step();
        end
        in_valid = 1'b0;
        check("mr_full", {31'b0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_valid_low", {31'b0, out_valid}, 32'd0);
        check("mr_data_zero", out_data, 32'd0);
        check("mr_in_ready", {31'b0, in_ready}, 32'd1);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("mr_no_stale", {31'b0, out_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter with valid/ready handshakes on both sides. It is the next-generation replacement for the single-cycle arithmetic-right-shift mux. It adds generic width N, selectable pipeline depth, four shift modes (SLL/SRL/SRA/ROR), backpressure and a synchronous flush. It sits between the ALU operand path and the writeback skid buffer, sustaining one operation per cycle.

## Interface
Parameters:
- N, 32, data width; power of two, 2 ≤ N ≤ 64.
- STAGES, 2, number of register slices; 1 ≤ STAGES ≤ clog2(N).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all in-flight operations.
- in_valid  input  1  input operation valid.
- in_ready  output  1  block can accept the operation this cycle.
- in_data  input  N  operand.
- in_shamt  input  clog2(N)  shift amount, unsigned.
- in_op  input  2  mode: 00 SLL, 01 SRL, 11 SRA, 10 ROR (rotate right).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  N  result.

## Operation
- Arithmetic, using L = clog2(N):
  - SLL: (in_data << shamt) truncated to N bits.
  - SRL: zero-filled right shift.
  - SRA: right shift filled with the original in_data[N-1].
  - ROR: {in_data, in_data} >> shamt, low N bits.
  - shamt = 0 returns in_data unchanged in every mode.
- Structure:
  - L shift levels. Level k shifts by 2^k when shamt[k] = 1.
  - Levels are split across STAGES slices in ascending k. Each slice takes ceil(L/STAGES) levels; the last slice takes the remainder.
  - Each slice ends in a register holding valid, data, unconsumed shamt bits, op, and the original sign bit.
- Handshake, per slice s (slice STAGES-1 drives out_*):
  - ready_s = !valid_s || ready_{s+1}.
  - ready_STAGES = out_ready.
  - in_ready = ready_0 && !flush.
  - A transfer occurs when valid && ready on the same edge.
  - Slice s loads from upstream when ready_s = 1. valid_s takes upstream valid, or in_valid && in_ready for slice 0.
  - When a slice holds (ready_s = 0), its data and valid are frozen.
- Ordering: results leave in acceptance order. No drops, no duplicates.
- Flush: on an edge with flush = 1, all valid_s ← 0. Data registers may keep stale contents. No input is accepted that cycle.
- The output is held stable while out_valid && !out_ready.
- in_op, in_shamt and in_data are sampled only on an accepting edge.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 0, all internal valid = 0, out_data = 0.
  - in_ready = 1 while rst_n is low and flush = 0.
- Latency: STAGES cycles from an accepting edge to out_valid = 1, when out_ready stays high.
- Throughput: one operation per cycle with out_ready = 1.
- Capacity: STAGES operations in flight. With out_ready held low, in_ready falls after STAGES accepts.
- in_ready depends combinationally on out_ready through the ready chain. out_valid and out_data are register outputs only.
- Same-edge accept at the tail and emit at the head is allowed when the pipe is full and out_ready = 1.
- Reset mid-operation: all in-flight operations are discarded immediately. The first accept after rst_n rises sees an empty pipe.
- flush and out_ready both high: the head result counts as consumed on that edge. After the edge the pipe is empty.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 1; nothing is emitted after release without a new accept.
- Modes (N = 32, STAGES = 2, out_ready = 1):
  - SRA 0x80000000 shamt 31 -> 0xFFFFFFFF.
  - SRL 0x80000000 shamt 31 -> 0x00000001.
  - SLL 0x00000001 shamt 31 -> 0x80000000.
  - ROR 0x00000001 shamt 4 -> 0x10000000.
  - Each result appears exactly 2 cycles after acceptance.
- Identity and streaming: 0xDEADBEEF shamt 0 in all four modes back-to-back -> four outputs of 0xDEADBEEF on consecutive cycles; in_ready stays 1.
- Backpressure: stream 0x1..0x4 as SRL shamt 0 with out_ready low for 5 cycles -> in_ready drops after 2 accepts; out_data holds 0x1; after release the outputs are 0x1, 0x2, 0x3, 0x4 in order.
- Flush: 2 operations in flight, pulse flush with in_valid = 1 -> no accept that cycle; out_valid = 0 next cycle; the next operation (SRA 0xF0000000 shamt 4) returns 0xFF000000 after 2 cycles.
- Reset mid-stream: drop rst_n between clock edges while the pipe is full -> out_valid goes low before the next edge; no stale results appear after release.
